// File: rtl/pt2272_symbol_decoder.sv
// PT2272-style front end: measures din pulse widths, classifies high/low pairs
// into tri-state symbols (0/1/F), detects sync bits and frames the symbol stream.
module pt2272_symbol_decoder #(
  parameter int ALPHA      = 16,
  parameter int FRAME_SYMS = 12,
  parameter int CW         = $clog2(64*ALPHA+1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  output logic       sym_valid,
  output logic [1:0] sym_code,
  output logic [3:0] sym_idx,
  output logic       sync_det,
  output logic       in_frame,
  output logic       frame_done,
  output logic       frame_err
);

  localparam logic [CW-1:0] W_2A     = CW'(2*ALPHA);
  localparam logic [CW-1:0] W_8A     = CW'(8*ALPHA);
  localparam logic [CW-1:0] W_16A    = CW'(16*ALPHA);
  localparam logic [CW-1:0] W_MAX    = CW'(64*ALPHA);
  localparam logic [CW-1:0] W_MAX_M1 = CW'(64*ALPHA-1);
  localparam logic [CW-1:0] W_ONE    = CW'(1);
  localparam logic [3:0]    LAST_IDX = 4'(FRAME_SYMS-1);

  typedef enum logic [1:0] {SEEK, P1, P2} state_t;
  typedef enum logic [1:0] {CLS_N, CLS_W, CLS_BAD} cls_t;

  logic          r_sync1, r_sync2, r_din_q;
  logic [CW-1:0] r_h, r_l;
  logic          r_rise_evt, r_sync_evt;
  cls_t          r_cls;

  logic w_rise, w_fall, w_sync_hit;
  logic w_h_narrow, w_h_wide, w_l_short, w_l_long;
  cls_t w_cls;

  assign w_rise     = r_sync2 & ~r_din_q;
  assign w_fall     = ~r_sync2 & r_din_q;
  assign w_h_narrow = (r_h >= W_2A) && (r_h < W_8A);
  assign w_h_wide   = (r_h >= W_8A) && (r_h < W_16A);
  assign w_l_short  = (r_l >= W_2A) && (r_l < W_8A);
  assign w_l_long   = (r_l >= W_8A) && (r_l < W_16A);
  assign w_cls      = (w_h_narrow && w_l_long)  ? CLS_N :
                      (w_h_wide   && w_l_short) ? CLS_W : CLS_BAD;
  // Fires only on the step into saturation, so an endless low reports once.
  assign w_sync_hit = ~r_sync2 & ~r_din_q & (r_l == W_MAX_M1) & w_h_narrow;

  // Counters track the value din_q is about to take, so at a rise edge r_h/r_l
  // hold exactly the widths of the pulse being closed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_din_q    <= 1'b0;
      r_h        <= '0;
      r_l        <= '0;
      r_rise_evt <= 1'b0;
      r_sync_evt <= 1'b0;
      r_cls      <= CLS_N;
    end else begin
      r_sync1 <= din;
      r_sync2 <= r_sync1;
      r_din_q <= r_sync2;
      if (w_rise)
        r_h <= W_ONE;
      else if (r_sync2 && (r_h != W_MAX))
        r_h <= r_h + W_ONE;
      if (w_fall)
        r_l <= W_ONE;
      else if (!r_sync2 && (r_l != W_MAX))
        r_l <= r_l + W_ONE;
      r_rise_evt <= w_rise;
      r_sync_evt <= w_sync_hit;
      if (w_rise)
        r_cls <= w_cls;
    end
  end

  state_t     r_state, w_state_nx;
  logic       r_skip, w_skip_nx;
  logic       r_half_w, w_half_w_nx;
  logic [3:0] r_idx, w_idx_nx;
  logic       w_vld_nx, w_sdet_nx, w_done_nx, w_err_nx, w_in_frame_nx;
  logic [1:0] w_code_nx;
  logic [3:0] w_sidx_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= SEEK;
      r_skip     <= 1'b0;
      r_half_w   <= 1'b0;
      r_idx      <= '0;
      sym_valid  <= 1'b0;
      sym_code   <= '0;
      sym_idx    <= '0;
      sync_det   <= 1'b0;
      in_frame   <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_skip     <= w_skip_nx;
      r_half_w   <= w_half_w_nx;
      r_idx      <= w_idx_nx;
      sym_valid  <= w_vld_nx;
      sym_code   <= w_code_nx;
      sym_idx    <= w_sidx_nx;
      sync_det   <= w_sdet_nx;
      in_frame   <= w_in_frame_nx;
      frame_done <= w_done_nx;
      frame_err  <= w_err_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_skip_nx   = r_skip;
    w_half_w_nx = r_half_w;
    w_idx_nx    = r_idx;
    w_vld_nx    = 1'b0;
    w_code_nx   = sym_code;
    w_sidx_nx   = sym_idx;
    w_sdet_nx   = 1'b0;
    w_done_nx   = 1'b0;
    w_err_nx    = 1'b0;
    if (r_sync_evt) begin
      // The rise after a sync only closes the sync pulse itself: skip it.
      w_sdet_nx  = 1'b1;
      w_err_nx   = (r_state != SEEK);
      w_state_nx = P1;
      w_skip_nx  = 1'b1;
      w_idx_nx   = '0;
    end else if (r_rise_evt && (r_state != SEEK)) begin
      if (r_skip) begin
        w_skip_nx = 1'b0;
      end else if (r_state == P1) begin
        if (r_cls == CLS_BAD) begin
          w_err_nx   = 1'b1;
          w_state_nx = SEEK;
        end else begin
          w_half_w_nx = (r_cls == CLS_W);
          w_state_nx  = P2;
        end
      end else if ((r_cls == CLS_BAD) || (r_half_w && (r_cls == CLS_N))) begin
        w_err_nx   = 1'b1;
        w_state_nx = SEEK;
      end else begin
        w_vld_nx  = 1'b1;
        w_sidx_nx = r_idx;
        if (r_half_w)
          w_code_nx = 2'b01;
        else if (r_cls == CLS_N)
          w_code_nx = 2'b00;
        else
          w_code_nx = 2'b10;
        if (r_idx == LAST_IDX) begin
          w_done_nx  = 1'b1;
          w_idx_nx   = '0;
          w_state_nx = SEEK;
        end else begin
          w_idx_nx   = r_idx + 4'd1;
          w_state_nx = P1;
        end
      end
    end
    w_in_frame_nx = (w_state_nx != SEEK) || w_done_nx;
  end

endmodule

// File: tb/tb_pt2272_symbol_decoder.sv
// Directed bench: drives pulse trains, predicts every output per cycle from a pulse-level model.
module tb_pt2272_symbol_decoder;
  localparam int A  = 4;
  localparam int FS = 12;
  localparam int NH = 4*A,  NL = 12*A;
  localparam int WH = 12*A, WL = 4*A;
  localparam int SH = 4*A,  SL = 124*A;

  logic       clk = 1'b0, rst = 1'b1, din = 1'b0;
  logic       sym_valid, sync_det, in_frame, frame_done, frame_err;
  logic [1:0] sym_code;
  logic [3:0] sym_idx;

  pt2272_symbol_decoder #(.ALPHA(A), .FRAME_SYMS(FS)) dut (
    .clk(clk), .rst(rst), .din(din),
    .sym_valid(sym_valid), .sym_code(sym_code), .sym_idx(sym_idx),
    .sync_det(sync_det), .in_frame(in_frame),
    .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0;
  bit rst_q = 1'b0;

  bit q_vld [int];
  int q_code [int];
  int q_idx [int];
  bit q_sdet [int];
  bit q_done [int];
  bit q_err [int];
  bit q_if [int];

  int exp_code = 0, exp_idx = 0, exp_if = 0;
  int n_vld = 0, n_sdet = 0, n_done = 0, n_err = 0;
  int last_sdet_cyc = -1, last_err_if = -1, last_err_sdet = -1;

  bit m_in = 0, m_have = 0, m_ign = 0;
  int m_half = 0, m_idx = 0;
  bit prev_ok = 0;
  int prev_h = 0, prev_l = 0, last_fall = 0;

  int frm [12] = '{0, 1, 2, 0, 0, 1, 1, 2, 2, 0, 1, 0};

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // 0 = narrow, 1 = wide, 2 = bad
  function automatic int cls(input int h, input int l);
    if (h >= 2*A && h < 8*A && l >= 8*A && l < 16*A) return 0;
    if (h >= 8*A && h < 16*A && l >= 2*A && l < 8*A) return 1;
    return 2;
  endfunction

  function automatic void m_error(input int c);
    q_err[c] = 1'b1;
    q_if[c]  = 1'b0;
    m_in     = 1'b0;
    m_have   = 1'b0;
  endfunction

  function automatic void m_eval(input int h, input int l, input int c);
    int k;
    if (!m_in) return;
    if (m_ign) begin
      m_ign = 1'b0;
      return;
    end
    k = cls(h, l);
    if (!m_have) begin
      if (k == 2) m_error(c);
      else begin
        m_have = 1'b1;
        m_half = k;
      end
    end else begin
      m_have = 1'b0;
      if (k == 2 || (m_half == 1 && k == 0)) m_error(c);
      else begin
        q_vld[c]  = 1'b1;
        q_code[c] = (m_half == 1) ? 1 : ((k == 0) ? 0 : 2);
        q_idx[c]  = m_idx;
        if (m_idx == FS-1) begin
          q_done[c]  = 1'b1;
          q_if[c+1]  = 1'b0;
          m_in       = 1'b0;
          m_idx      = 0;
        end else m_idx++;
      end
    end
  endfunction

  function automatic void m_sync(input int c);
    q_sdet[c] = 1'b1;
    if (m_in) q_err[c] = 1'b1;
    else q_if[c] = 1'b1;
    m_in = 1'b1; m_idx = 0; m_have = 1'b0; m_ign = 1'b1;
  endfunction

  task automatic send_pulse(input int h, input int l);
    int t;
    t = cyc;
    if (prev_ok) m_eval(prev_h, prev_l, t + 4);
    din = 1'b1;
    repeat (h) @(negedge clk);
    din = 1'b0;
    last_fall = cyc;
    if (h >= 2*A && h < 8*A && l >= 64*A) m_sync(cyc + 64*A + 3);
    repeat (l) @(negedge clk);
    prev_h = h; prev_l = l; prev_ok = 1'b1;
  endtask

  task automatic send_sym(input int s);
    case (s)
      0:       begin send_pulse(NH, NL); send_pulse(NH, NL); end
      1:       begin send_pulse(WH, WL); send_pulse(WH, WL); end
      default: begin send_pulse(NH, NL); send_pulse(WH, WL); end
    endcase
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_in = 1'b0; m_have = 1'b0; m_ign = 1'b0; m_idx = 0; prev_ok = 1'b0;
  endtask

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  always @(negedge clk) begin
    int e_vld, e_sdet, e_done, e_err;
    e_vld = 0; e_sdet = 0; e_done = 0; e_err = 0;
    if (rst_q) begin
      exp_code = 0; exp_idx = 0; exp_if = 0;
    end else begin
      if (q_vld.exists(cyc)) begin
        e_vld = 1; exp_code = q_code[cyc]; exp_idx = q_idx[cyc];
      end
      if (q_sdet.exists(cyc)) e_sdet = 1;
      if (q_done.exists(cyc)) e_done = 1;
      if (q_err.exists(cyc))  e_err = 1;
      if (q_if.exists(cyc))   exp_if = int'(q_if[cyc]);
    end
    check("sym_valid",  int'(sym_valid),  e_vld);
    check("sync_det",   int'(sync_det),   e_sdet);
    check("frame_done", int'(frame_done), e_done);
    check("frame_err",  int'(frame_err),  e_err);
    check("in_frame",   int'(in_frame),   exp_if);
    check("sym_code",   int'(sym_code),   exp_code);
    check("sym_idx",    int'(sym_idx),    exp_idx);
    n_vld  += int'(sym_valid);
    n_done += int'(frame_done);
    if (sync_det) begin n_sdet++; last_sdet_cyc = cyc; end
    if (frame_err) begin
      n_err++; last_err_if = int'(in_frame); last_err_sdet = int'(sync_det);
    end
  end

  initial begin
    int bv, bd, be;
    rst = 1'b1; din = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // idle low, then a single sync
    repeat (600) @(negedge clk);
    check("idle_sdet_cnt", n_sdet, 0);
    check("idle_in_frame", int'(in_frame), 0);
    send_pulse(SH, SL);
    check("sync_latency", last_sdet_cyc - last_fall, 259);
    check("sync_cnt", n_sdet, 1);
    check("sync_in_frame", int'(in_frame), 1);

    // full frame
    bv = n_vld; bd = n_done; be = n_err;
    for (int i = 0; i < 12; i++) send_sym(frm[i]);
    send_pulse(SH, SL);
    check("frame_vld_cnt", n_vld - bv, 12);
    check("frame_done_cnt", n_done - bd, 1);
    check("frame_err_cnt", n_err - be, 0);

    // W then N is illegal
    bv = n_vld; be = n_err;
    send_pulse(WH, WL); send_pulse(NH, NL); send_pulse(SH, SL);
    check("wn_err_cnt", n_err - be, 1);
    check("wn_in_frame_at_err", last_err_if, 0);
    check("wn_vld_cnt", n_vld - bv, 0);
    bv = n_vld; bd = n_done;
    for (int i = 0; i < 12; i++) send_sym(frm[i]);
    send_pulse(SH, SL);
    check("refrm_vld_cnt", n_vld - bv, 12);
    check("refrm_done_cnt", n_done - bd, 1);

    // premature sync after 5 symbols (previous sync already armed a frame)
    bv = n_vld; be = n_err;
    for (int i = 0; i < 5; i++) send_sym(frm[i]);
    send_pulse(SH, SL);
    check("pre_vld_cnt", n_vld - bv, 5);
    check("pre_err_cnt", n_err - be, 1);
    check("pre_err_with_sdet", last_err_sdet, 1);
    check("pre_in_frame_at_err", last_err_if, 1);
    send_sym(1);

    // width boundaries: H31/L33 narrow, H32/L16 wide, H7 bad
    send_pulse(31, 33);
    check("pre_next_idx", int'(sym_idx), 0);
    check("pre_next_code", int'(sym_code), 1);
    send_pulse(NH, NL);
    send_pulse(32, 16);
    check("b_narrow_code", int'(sym_code), 0);
    check("b_narrow_idx", int'(sym_idx), 1);
    send_pulse(WH, WL);
    send_pulse(7, 48);
    check("b_wide_code", int'(sym_code), 1);
    check("b_wide_idx", int'(sym_idx), 2);
    be = n_err;
    send_pulse(SH, SL);
    check("b_h7_err_cnt", n_err - be, 1);
    check("b_resync_in_frame", int'(in_frame), 1);

    // reset in the middle of symbol 6
    be = n_err;
    for (int i = 0; i < 6; i++) send_sym(frm[i]);
    send_pulse(NH, NL);
    do_reset();
    check("rst_in_frame", int'(in_frame), 0);
    check("rst_sym_idx", int'(sym_idx), 0);
    check("rst_err_cnt", n_err - be, 0);
    send_pulse(SH, SL);
    check("rst_resync_in_frame", int'(in_frame), 1);
    send_sym(2);
    send_pulse(SH, SL);
    check("rst_first_idx", int'(sym_idx), 0);
    check("rst_first_code", int'(sym_code), 2);

    repeat (10) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
